// File: rtl/booth4_pkg.sv
// booth4_pkg: shared definitions for the sequential radix-4 Booth multiplier.
// It holds the FSM state encoding, the Booth digit select encoding, the default
// sizes, and the digit encoder that turns three multiplier bits into a select.
package booth4_pkg;

    localparam int WIDTH_DEF = 8;
    localparam int ND        = WIDTH_DEF / 2;
    localparam int PW        = 2 * WIDTH_DEF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // The magnitude is one-hot: 'one' selects A and 'two' selects 2A.
    // 'neg' requests the negated multiple.
    typedef struct packed {
        logic neg;
        logic two;
        logic one;
    } booth_sel_t;

    // The digit -2*b[2k+1] + b[2k] + b[2k-1] is split into sign and magnitude.
    // Patterns 000 and 111 are zero and never assert neg.
    function automatic booth_sel_t booth_encode(input logic [2:0] bits);
        booth_sel_t s;
        s.neg = bits[2] & ~(bits[1] & bits[0]);
        s.one = bits[1] ^ bits[0];
        s.two = (bits == 3'b011) || (bits == 3'b100);
        return s;
    endfunction

endpackage

// File: rtl/booth4_mult_seq_if.sv
// booth4_mult_seq_if: operand/product handshake bundle of the Booth multiplier.
// The slave side is the multiplier. The master side is the operand source and
// the product consumer.
interface booth4_mult_seq_if import booth4_pkg::*; #(
    parameter int WIDTH = WIDTH_DEF
);

    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     a_i;
    logic [WIDTH-1:0]     b_i;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   prod_o;

    modport master (
        output in_valid, a_i, b_i, out_ready,
        input  in_ready, out_valid, prod_o
    );

    modport slave (
        input  in_valid, a_i, b_i, out_ready,
        output in_ready, out_valid, prod_o
    );

endinterface

// File: rtl/booth4_pp_sel.sv
// booth4_pp_sel: combinational Booth partial-product selector.
// It uses three multiplier bits to pick 0, +-A or +-2A as a WIDTH+2-bit signed value.
// -A is built by invert-plus-one in WIDTH+1 bits, so negating the most
// negative operand stays exact.
module booth4_pp_sel import booth4_pkg::*; #(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic [2:0]       mult_bits,
    input  logic [WIDTH-1:0] a,
    output logic [WIDTH+1:0] pp
);

    booth_sel_t     sel;
    logic [WIDTH:0] a_pos;
    logic [WIDTH:0] a_neg;
    logic [WIDTH:0] a_sel;

    // Decode the digit, choose the signed multiple and scale it by 1 or 2.
    always_comb begin
        sel   = booth_encode(mult_bits);
        a_pos = {a[WIDTH-1], a};
        a_neg = ~a_pos + (WIDTH+1)'(1);
        a_sel = sel.neg ? a_neg : a_pos;
        pp    = '0;
        if (sel.two) begin
            pp = {a_sel, 1'b0};
        end else if (sel.one) begin
            pp = {a_sel[WIDTH], a_sel};
        end
    end

endmodule

// File: rtl/booth4_mult_seq.sv
// booth4_mult_seq: iterative signed radix-4 Booth multiplier.
// It retires one Booth digit per clock into a 2*WIDTH-bit accumulator. The product
// is registered and held under out_valid/out_ready backpressure.
// Optional feature macro: BOOTH4_ZERO_SKIP_EN. When it is defined, the
// calculation stops early once every remaining multiplier bit is a sign copy.
module booth4_mult_seq import booth4_pkg::*; #(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic                     sys_clk,
    input  logic                     sys_rst,
    booth4_mult_seq_if.slave         bus
);

    localparam int NDIG = WIDTH / 2;
    localparam int PWID = 2 * WIDTH;
    localparam int KW   = $clog2(NDIG);

    state_t            state_q;
    state_t            state_d;
    logic              in_ready;
    logic              out_valid;
    logic              accept;
    logic              calc_last;

    logic [WIDTH-1:0]  a_q;
    logic [WIDTH:0]    mult_q;
    logic [KW-1:0]     k_q;
    logic [PWID-1:0]   acc_q;
    logic [PWID-1:0]   prod_q;

    logic [WIDTH+1:0]  pp;
    logic [PWID-1:0]   pp_ext;
    logic [PWID-1:0]   pp_shift;
    logic [PWID-1:0]   acc_next;

    assign accept = (state_q == IDLE) && bus.in_valid;

    // The low three bits of the shifted multiplier always hold the current
    // digit's window b[2k+1], b[2k], b[2k-1].
    booth4_pp_sel #(
        .WIDTH (WIDTH)
    ) u_pp_sel (
        .mult_bits (mult_q[2:0]),
        .a         (a_q),
        .pp        (pp)
    );

    assign pp_ext   = {{(PWID-WIDTH-2){pp[WIDTH+1]}}, pp};
    assign pp_shift = pp_ext << {k_q, 1'b0};
    assign acc_next = acc_q + pp_shift;

`ifdef BOOTH4_ZERO_SKIP_EN
    // The multiplier shifts arithmetically, so mult_q[WIDTH:2] covers every bit
    // above the current digit. If those bits all match, every later digit is zero.
    logic [WIDTH-2:0] rest_bits;
    assign rest_bits = mult_q[WIDTH:2];
    assign calc_last = (k_q == KW'(NDIG-1)) || (rest_bits == '0) || (rest_bits == '1);
`else
    assign calc_last = (k_q == KW'(NDIG-1));
`endif

    // State register, with a synchronous return to IDLE on reset.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state selection and handshake outputs; the two never overlap, so
    // in_ready is only high in IDLE and out_valid only in DONE.
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (bus.in_valid) begin
                    state_d = CALC;
                end
            end
            CALC: begin
                if (calc_last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Datapath: latch the operands on accept, add one shifted partial product per
    // CALC cycle, and load the product register on the final digit. A reset
    // discards any in-flight work.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            a_q    <= '0;
            mult_q <= '0;
            k_q    <= '0;
            acc_q  <= '0;
            prod_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        a_q    <= bus.a_i;
                        mult_q <= {bus.b_i, 1'b0};
                        k_q    <= '0;
                        acc_q  <= '0;
                    end
                end
                CALC: begin
                    acc_q  <= acc_next;
                    mult_q <= {{2{mult_q[WIDTH]}}, mult_q[WIDTH:2]};
                    k_q    <= k_q + KW'(1);
                    if (calc_last) begin
                        prod_q <= acc_next;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.prod_o    = prod_q;

endmodule
